inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
// - Interrupt-acknowledge sequencer of the 8259A PIC (8086 mode, two INTA pulses). Sits directly
//   upstream of CascadeController: asks it to drive/release CAS, consumes its slave flag.
// - Takes the winning IR level from the priority resolver and CPU INTA_n; updates ISR/IRR, drives the
//   vector {ICW2[7:3], level} onto the data bus, issues AEOI.
// PARAMETERS
// - GAP_TIMEOUT  255  max clk cycles waiting for INTA2 (in GAP) before abort; 8-bit counter
// PORTS
// - clk            in   1  single system clock; all logic on rising edge
// - reset          in   1  synchronous, active-high; clears all state
// - int_req        in   1  priority resolver has an unmasked request of higher priority than ISR
// - int_level      in   3  IR number of that request
// - INTA_n         in   1  CPU acknowledge, active low; sampled each clk, edges detected internally
// - SP             in   1  1 = master/single, 0 = slave
// - SNGL           in   1  1 = single PIC, no cascade
// - ICW2           in   8  vector base; bits [7:3] used
// - ICW3           in   8  master: IRs that carry a slave
// - AEOI           in   1  automatic EOI enabled (ICW4)
// - flag           in   1  slave: CAS matched own ID (from CascadeController)
// - INT            out  1  interrupt output to CPU / master IR pin
// - control_signal out  1  master: 1-cycle pulse, CascadeController loads desired_slave onto CAS
// - desired_slave  out  3  master: slave ID to put on CAS
// - EOI            out  1  master: 1-cycle pulse, CascadeController releases CAS (3'bzzz)
// - flag_ACK       out  1  slave: 1-cycle pulse, clears CascadeController flag
// - isr_set        out  8  one-hot, 1-cycle: set ISR bit; clear IRR bit
// - isr_clr        out  8  one-hot, 1-cycle: clear ISR bit (AEOI)
// - data_out       out  8  vector byte
// - data_oe        out  1  data bus drive enable
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; inta_q=1 (no false edge); timer 0; latched level 0.
// - fall = inta_q & ~INTA_n; rise = ~inta_q & INTA_n; inta_q registers INTA_n each clk.
// - cascaded = SP & ~SNGL & ICW3[lvl]; lvl = level latched at INTA1 fall.
// - IDLE: INT=0. int_req=1 -> REQ next cycle. An INTA fall seen in IDLE is ignored.
// - REQ: INT=1. int_req may change; level tracks int_level. On fall -> ACK1:
//   - int_req=1: lvl=int_level; isr_set=1<<lvl for 1 cycle.
//   - int_req=0: spurious; lvl=7, no isr_set.
//   - master & cascaded: control_signal pulses and desired_slave=lvl in the same cycle.
//   - slave: isr_set as above (uses own int_level); no CAS action.
// - ACK1: INT=0; on rise -> GAP, timer cleared.
// - GAP: timer++ each cycle; fall -> ACK2; timer reaching GAP_TIMEOUT -> ABORT.
// - ACK2: data_out={ICW2[7:3],lvl} from the cycle after the fall.
//   - data_oe=1 if (SP & ~cascaded) | (~SP & flag), else 0.
//   - rise -> DONE; data_oe drops on the rise cycle.
// - DONE (1 cycle):
//   - AEOI=1 & not spurious: isr_clr=1<<lvl.
//   - master & cascaded: EOI pulse.
//   - slave & flag: flag_ACK pulse.
//   - -> IDLE; back-to-back REQ allowed the next cycle.
// - ABORT (1 cycle): EOI pulse if master & cascaded; no isr_clr; ISR left set; -> IDLE.
// - Mid-sequence reset: all outputs 0 next clk; CAS is not actively released (reset covers the controller).
// - Same desired_slave on consecutive acks still gives a fresh control_signal pulse.
// - INTA fall and rise never coincide; a glitch shorter than 1 clk is not detected (by design).
// TESTING
// - Master, SNGL=1, ICW2=8'h40, IR3: INTA pair -> isr_set=8'h08, data_out=8'h43, data_oe=1, no CAS pulses.
// - Master cascaded, ICW3=8'h40, IR6, AEOI=1:
//   - -> control_signal pulse, desired_slave=3'b110, data_oe=0 in ACK2.
//   - DONE -> EOI pulse, isr_clr=8'h40.
// - Slave, ICW2=8'h70, IR2, flag=1 at INTA2 -> data_out=8'h72, data_oe=1, flag_ACK pulse; flag=0 -> data_oe=0.
// - int_req dropped before INTA1 -> spurious: isr_set=0, data_out={ICW2[7:3],3'b111}, no isr_clr.
// - No INTA2 for GAP_TIMEOUT cycles (cascaded) -> EOI pulse, IDLE, data_oe never asserted.
// - Reset asserted during ACK2 -> next clk: data_oe=0, INT=0, state IDLE; two back-to-back acks to slave 5 -> two control_signal pulses.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259A interrupt-acknowledge sequencer (8086 mode, two INTA pulses).
// Takes the winning IR level and the CPU INTA_n strobe. It updates ISR/IRR,
// drives the vector byte, and issues AEOI. In master mode it also drives the
// cascade controller.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   int_req, int_level  pending request from the priority resolver and its IR number
//   INTA_n              CPU acknowledge strobe (active low, edges detected here)
//   SP, SNGL            master/slave select, single-PIC mode
//   ICW2, ICW3, AEOI    vector base, slave map, automatic-EOI enable
//   flag                slave: CAS matched own ID
//   INT                 interrupt request to CPU / master IR pin
//   control_signal      master: load desired_slave onto CAS (1-cycle pulse)
//   desired_slave       master: slave ID for CAS
//   EOI                 master: release CAS (1-cycle pulse)
//   flag_ACK            slave: clear cascade flag (1-cycle pulse)
//   isr_set, isr_clr    one-hot ISR set (and IRR clear) / ISR clear pulses
//   data_out, data_oe   vector byte and data-bus drive enable
module inta_sequencer #(
  parameter int unsigned GAP_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic       INTA_n,
  input  logic       SP,
  input  logic       SNGL,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW3,
  input  logic       AEOI,
  input  logic       flag,
  output logic       INT,
  output logic       control_signal,
  output logic [2:0] desired_slave,
  output logic       EOI,
  output logic       flag_ACK,
  output logic [7:0] isr_set,
  output logic [7:0] isr_clr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned VEC_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK1, S_GAP, S_ACK2, S_DONE, S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic                 inta_q;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic                 spur_q, spur_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic                 int_d, control_d, eoi_d, flag_ack_d, data_oe_d;
  logic [LVL_W-1:0]     desired_slave_d;
  logic [VEC_W-1:0]     isr_set_d, isr_clr_d, data_out_d;

  logic                 fall_c, rise_c, cascaded_c;
  logic [VEC_W-1:0]     lvl_onehot_c;

  // Low vector bits come from the level, not from ICW2.
  logic unused_icw2_c;
  assign unused_icw2_c = &{1'b0, ICW2[2:0]};

  assign fall_c = inta_q & ~INTA_n;
  assign rise_c = ~inta_q & INTA_n;

  // Next state, latched level/timer, and next values of the registered outputs.
  always_comb begin
    state_d         = state_q;
    lvl_d           = lvl_q;
    spur_d          = spur_q;
    timer_d         = timer_q;
    int_d           = 1'b0;
    control_d       = 1'b0;
    desired_slave_d = desired_slave;
    eoi_d           = 1'b0;
    flag_ack_d      = 1'b0;
    isr_set_d       = '0;
    isr_clr_d       = '0;
    data_out_d      = '0;
    data_oe_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (int_req) state_d = S_REQ;
      end
      S_REQ: begin
        if (fall_c) begin
          state_d = S_ACK1;
          if (int_req) begin
            lvl_d  = int_level;
            spur_d = 1'b0;
          end else begin
            lvl_d  = LVL_W'(7);
            spur_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (rise_c) begin
          state_d = S_GAP;
          timer_d = '0;
        end
      end
      S_GAP: begin
        if (fall_c) begin
          state_d = S_ACK2;
        end else begin
          timer_d = TIMER_W'(timer_q + 1'b1);
          if (timer_d == TIMER_W'(GAP_TIMEOUT)) state_d = S_ABORT;
        end
      end
      S_ACK2: begin
        if (rise_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Evaluated on the level that will be latched, so the INTA1 cycle sees the new level.
    cascaded_c   = SP & ~SNGL & ICW3[lvl_d];
    lvl_onehot_c = VEC_W'(1) << lvl_d;

    int_d = (state_d == S_REQ);

    if (state_q == S_REQ && state_d == S_ACK1) begin
      isr_set_d = spur_d ? '0 : lvl_onehot_c;
      control_d = cascaded_c;
      if (cascaded_c) desired_slave_d = lvl_d;
    end

    if (state_d == S_ACK2) begin
      data_out_d = {ICW2[7:3], lvl_d};
      data_oe_d  = (SP & ~cascaded_c) | (~SP & flag);
    end

    if (state_d == S_DONE) begin
      isr_clr_d  = (AEOI & ~spur_d) ? lvl_onehot_c : '0;
      eoi_d      = cascaded_c;
      flag_ack_d = ~SP & flag;
    end

    if (state_d == S_ABORT) eoi_d = cascaded_c;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      inta_q         <= 1'b1;
      lvl_q          <= '0;
      spur_q         <= 1'b0;
      timer_q        <= '0;
      INT            <= 1'b0;
      control_signal <= 1'b0;
      desired_slave  <= '0;
      EOI            <= 1'b0;
      flag_ACK       <= 1'b0;
      isr_set        <= '0;
      isr_clr        <= '0;
      data_out       <= '0;
      data_oe        <= 1'b0;
    end else begin
      state_q        <= state_d;
      inta_q         <= INTA_n;
      lvl_q          <= lvl_d;
      spur_q         <= spur_d;
      timer_q        <= timer_d;
      INT            <= int_d;
      control_signal <= control_d;
      desired_slave  <= desired_slave_d;
      EOI            <= eoi_d;
      flag_ACK       <= flag_ack_d;
      isr_set        <= isr_set_d;
      isr_clr        <= isr_clr_d;
      data_out       <= data_out_d;
      data_oe        <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus queues expected output events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset, int_req, INTA_n, SP, SNGL, AEOI, flag;
  logic [2:0] int_level;
  logic [7:0] ICW2, ICW3;
  logic       INT, control_signal, EOI, flag_ACK, data_oe;
  logic [2:0] desired_slave;
  logic [7:0] isr_set, isr_clr, data_out;

  always #5 clk = ~clk;

  inta_sequencer #(.GAP_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_level(int_level),
    .INTA_n(INTA_n), .SP(SP), .SNGL(SNGL), .ICW2(ICW2), .ICW3(ICW3),
    .AEOI(AEOI), .flag(flag), .INT(INT), .control_signal(control_signal),
    .desired_slave(desired_slave), .EOI(EOI), .flag_ACK(flag_ACK),
    .isr_set(isr_set), .isr_clr(isr_clr), .data_out(data_out), .data_oe(data_oe)
  );

  typedef struct packed {
    logic       ctrl;
    logic [2:0] ds;
    logic       eoi;
    logic       fack;
    logic [7:0] iset;
    logic [7:0] iclr;
    logic [7:0] dout;
    logic       oe;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic ev_t mk(input logic ctrl, input logic [2:0] ds, input logic eoi,
                             input logic fack, input logic [7:0] iset, input logic [7:0] iclr,
                             input logic [7:0] dout, input logic oe);
    ev_t e;
    e.ctrl = ctrl; e.ds = ds; e.eoi = eoi; e.fack = fack;
    e.iset = iset; e.iclr = iclr; e.dout = dout; e.oe = oe;
    return e;
  endfunction

  // Monitor: an event is any pulse output, or the first cycle of a new vector on data_out.
  logic [7:0] prev_dout = 8'h00;
  always @(negedge clk) begin : monitor
    ev_t  ev;
    ev_t  exp_ev;
    logic onset;
    onset   = (data_out != 8'h00) && (prev_dout == 8'h00);
    ev.ctrl = control_signal;
    ev.ds   = control_signal ? desired_slave : 3'd0;
    ev.eoi  = EOI;
    ev.fack = flag_ACK;
    ev.iset = isr_set;
    ev.iclr = isr_clr;
    ev.dout = onset ? data_out : 8'h00;
    ev.oe   = onset ? data_oe : 1'b0;
    if (ev != '0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got %h, expected none", ev);
      end else begin
        exp_ev = sb.pop_front();
        if (ev !== exp_ev) begin
          n_err++;
          $display("FAIL event: got %h, expected %h", ev, exp_ev);
        end
      end
    end
    prev_dout = data_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int i;
    cyc(1);
    i = 0;
    while (sb.size() != 0 && i < 50) begin
      cyc(1);
      i++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d events still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Full two-pulse acknowledge; spur drops int_req before INTA1, flg is the slave flag at INTA2.
  task automatic ack(input logic [2:0] lvl, input logic spur, input logic flg);
    int_req = 1'b1; int_level = lvl;
    cyc(1);
    chk("INT_in_REQ", 32'(INT), 32'd1);
    if (spur) begin
      int_req = 1'b0;
      cyc(1);
      chk("INT_spur_REQ", 32'(INT), 32'd1);
    end
    INTA_n = 1'b0;
    cyc(1);
    chk("INT_after_INTA1", 32'(INT), 32'd0);
    int_req = 1'b0;
    cyc(1);
    INTA_n = 1'b1;
    cyc(2);
    flag = flg;
    INTA_n = 1'b0;
    cyc(2);
    INTA_n = 1'b1;
    cyc(1);
    chk("oe_drop_on_rise", 32'(data_oe), 32'd0);
    cyc(2);
    flag = 1'b0;
    drain();
  endtask

  task automatic cfg(input logic sp, input logic sngl, input logic [7:0] icw2,
                     input logic [7:0] icw3, input logic aeoi);
    SP = sp; SNGL = sngl; ICW2 = icw2; ICW3 = icw3; AEOI = aeoi;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; int_req = 1'b0; int_level = 3'd0; INTA_n = 1'b1; flag = 1'b0;
    cfg(1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    cyc(2);
    chk("rst_INT", 32'(INT), 32'd0);
    chk("rst_data_oe", 32'(data_oe), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_isr_set", 32'(isr_set), 32'd0);
    chk("rst_desired_slave", 32'(desired_slave), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Single master, IR3.
    cfg(1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h08, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h43, 1));
    ack(3'd3, 1'b0, 1'b0);

    // Cascaded master, IR6 carries a slave, AEOI.
    cfg(1'b1, 1'b0, 8'h40, 8'h40, 1'b1);
    sb.push_back(mk(1, 3'd6, 0, 0, 8'h40, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h46, 0));
    sb.push_back(mk(0, 3'd0, 1, 0, 8'h00, 8'h40, 8'h00, 0));
    ack(3'd6, 1'b0, 1'b0);

    // Slave, flag set at INTA2.
    cfg(1'b0, 1'b0, 8'h70, 8'h00, 1'b0);
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h04, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h72, 1));
    sb.push_back(mk(0, 3'd0, 0, 1, 8'h00, 8'h00, 8'h00, 0));
    ack(3'd2, 1'b0, 1'b1);

    // Slave, not addressed.
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h04, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h72, 0));
    ack(3'd2, 1'b0, 1'b0);

    // Spurious: request withdrawn before INTA1.
    cfg(1'b1, 1'b1, 8'h48, 8'h00, 1'b1);
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h4F, 1));
    ack(3'd5, 1'b1, 1'b0);

    // INTA2 never arrives: abort with EOI, no vector.
    cfg(1'b1, 1'b0, 8'h40, 8'h40, 1'b1);
    sb.push_back(mk(1, 3'd6, 0, 0, 8'h40, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
    int_req = 1'b1; int_level = 3'd6;
    cyc(1);
    INTA_n = 1'b0;
    cyc(1);
    int_req = 1'b0;
    cyc(1);
    INTA_n = 1'b1;
    cyc(250);
    chk("no_abort_yet_oe", 32'(data_oe), 32'd0);
    chk("no_abort_yet_pending", 32'(sb.size()), 32'd1);
    cyc(20);
    drain();
    chk("after_abort_INT", 32'(INT), 32'd0);

    // Reset asserted while in ACK2.
    cfg(1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h02, 8'h00, 8'h00, 0));
    sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h41, 1));
    int_req = 1'b1; int_level = 3'd1;
    cyc(1);
    INTA_n = 1'b0;
    cyc(1);
    int_req = 1'b0;
    cyc(1);
    INTA_n = 1'b1;
    cyc(2);
    INTA_n = 1'b0;
    cyc(2);
    chk("ack2_oe", 32'(data_oe), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("midrst_oe", 32'(data_oe), 32'd0);
    chk("midrst_INT", 32'(INT), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    INTA_n = 1'b1;
    cyc(3);
    chk("post_rst_INT", 32'(INT), 32'd0);
    drain();

    // Two back-to-back acks to the slave on IR5.
    cfg(1'b1, 1'b0, 8'h40, 8'h20, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(1, 3'd5, 0, 0, 8'h20, 8'h00, 8'h00, 0));
      sb.push_back(mk(0, 3'd0, 0, 0, 8'h00, 8'h00, 8'h45, 0));
      sb.push_back(mk(0, 3'd0, 1, 0, 8'h00, 8'h00, 8'h00, 0));
      ack(3'd5, 1'b0, 1'b0);
    end
    chk("final_desired_slave", 32'(desired_slave), 32'd5);

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
